// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin arbiter feeding one Avalon-ST sink; a source keeps the output until its eop word transfers.
// Define ARB_STAT_EN to add per-source packet counters and a stray-word drop counter.
module ast_packet_arbiter #(
   parameter int NUM_SRC       = 2,
   parameter int AST_DWIDTH    = 64,
   parameter int CHANNEL_WIDTH = 1,
   parameter int EMPTY_WIDTH   = $clog2(AST_DWIDTH / 8),
   parameter int ID_WIDTH      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                             clk_i,
   input  logic                             arst_n_i,
   input  logic [NUM_SRC-1:0]               sink_valid_i,
   input  logic [NUM_SRC*AST_DWIDTH-1:0]    sink_data_i,
   input  logic [NUM_SRC-1:0]               sink_startofpacket_i,
   input  logic [NUM_SRC-1:0]               sink_endofpacket_i,
   input  logic [NUM_SRC*EMPTY_WIDTH-1:0]   sink_empty_i,
   input  logic [NUM_SRC*CHANNEL_WIDTH-1:0] sink_channel_i,
   output logic [NUM_SRC-1:0]               sink_ready_o,
   output logic                             src_valid_o,
   output logic [AST_DWIDTH-1:0]            src_data_o,
   output logic                             src_startofpacket_o,
   output logic                             src_endofpacket_o,
   output logic [EMPTY_WIDTH-1:0]           src_empty_o,
   output logic [CHANNEL_WIDTH-1:0]         src_channel_o,
   input  logic                             src_ready_i,
   output logic [ID_WIDTH-1:0]              src_id_o,
`ifdef ARB_STAT_EN
   output logic [NUM_SRC*16-1:0]            pkt_cnt_o,
   output logic [15:0]                      drop_cnt_o,
`endif
   output logic                             busy_o
);

   typedef enum logic [0:0] {
      IDLE,
      GRANT
   } state_t;

   state_t              state_q, state_d;
   logic [ID_WIDTH-1:0] grant_q, grant_d;
   logic [ID_WIDTH-1:0] last_q, last_d;
   logic [NUM_SRC-1:0]  req;
   logic [NUM_SRC-1:0]  stray;
   logic [ID_WIDTH-1:0] rr_sel;
   logic [ID_WIDTH-1:0] cand;
   logic                rr_found;
   logic                xfer;
   logic                eop_xfer;

   assign req = sink_valid_i & sink_startofpacket_i;

   // Scan from the farthest offset down so the nearest requester after last_q wins.
   always_comb begin
      rr_sel   = '0;
      rr_found = 1'b0;
      cand     = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         cand = ID_WIDTH'((int'(last_q) + k) % NUM_SRC);
         if (req[cand]) begin
            rr_sel   = cand;
            rr_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_d       = last_q;
      sink_ready_o = '0;
      src_valid_o  = 1'b0;
      xfer         = 1'b0;
      eop_xfer     = 1'b0;
      stray        = '0;
      case (state_q)
         IDLE: begin
            stray        = sink_valid_i & ~sink_startofpacket_i;
            sink_ready_o = stray;
            if (rr_found) begin
               grant_d = rr_sel;
               state_d = GRANT;
            end
         end
         GRANT: begin
            src_valid_o           = sink_valid_i[grant_q];
            sink_ready_o[grant_q] = src_ready_i;
            xfer                  = sink_valid_i[grant_q] & src_ready_i;
            eop_xfer              = xfer & sink_endofpacket_i[grant_q];
            if (eop_xfer) begin
               state_d = IDLE;
               last_d  = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
      // Stray-word acceptance would otherwise stay visible while reset is held.
      if (!arst_n_i) begin
         sink_ready_o = '0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= ID_WIDTH'(NUM_SRC - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign src_data_o          = sink_data_i[int'(grant_q)*AST_DWIDTH +: AST_DWIDTH];
   assign src_startofpacket_o = sink_startofpacket_i[grant_q];
   assign src_endofpacket_o   = sink_endofpacket_i[grant_q];
   assign src_empty_o         = sink_empty_i[int'(grant_q)*EMPTY_WIDTH +: EMPTY_WIDTH];
   assign src_channel_o       = sink_channel_i[int'(grant_q)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
   assign src_id_o            = grant_q;
   assign busy_o              = (state_q == GRANT);

`ifdef ARB_STAT_EN
   logic [15:0] pkt_cnt_q [NUM_SRC];
   logic [15:0] drop_cnt_q;
   logic [16:0] drop_sum;

   assign drop_sum = {1'b0, drop_cnt_q} + 17'($countones(stray));

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int n = 0; n < NUM_SRC; n++) begin
            pkt_cnt_q[n] <= '0;
         end
         drop_cnt_q <= '0;
      end else begin
         for (int n = 0; n < NUM_SRC; n++) begin
            if (eop_xfer && (grant_q == ID_WIDTH'(n)) && (pkt_cnt_q[n] != 16'hFFFF)) begin
               pkt_cnt_q[n] <= pkt_cnt_q[n] + 16'd1;
            end
         end
         drop_cnt_q <= (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
      end
   end

   for (genvar n = 0; n < NUM_SRC; n++) begin : g_pkt_cnt
      assign pkt_cnt_o[n*16 +: 16] = pkt_cnt_q[n];
   end
   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Scoreboard bench for ast_packet_arbiter: queued source models, expected words checked in arrival order.
module tb_ast_packet_arbiter;

   localparam int NUM_SRC       = 2;
   localparam int AST_DWIDTH    = 64;
   localparam int CHANNEL_WIDTH = 1;
   localparam int EMPTY_WIDTH   = 3;
   localparam int ID_WIDTH      = 1;

   logic                             clk_i;
   logic                             arst_n_i;
   logic [NUM_SRC-1:0]               sink_valid_i;
   logic [NUM_SRC*AST_DWIDTH-1:0]    sink_data_i;
   logic [NUM_SRC-1:0]               sink_startofpacket_i;
   logic [NUM_SRC-1:0]               sink_endofpacket_i;
   logic [NUM_SRC*EMPTY_WIDTH-1:0]   sink_empty_i;
   logic [NUM_SRC*CHANNEL_WIDTH-1:0] sink_channel_i;
   logic [NUM_SRC-1:0]               sink_ready_o;
   logic                             src_valid_o;
   logic [AST_DWIDTH-1:0]            src_data_o;
   logic                             src_startofpacket_o;
   logic                             src_endofpacket_o;
   logic [EMPTY_WIDTH-1:0]           src_empty_o;
   logic [CHANNEL_WIDTH-1:0]         src_channel_o;
   logic                             src_ready_i;
   logic [ID_WIDTH-1:0]              src_id_o;
   logic                             busy_o;
`ifdef ARB_STAT_EN
   logic [NUM_SRC*16-1:0]            pkt_cnt_o;
   logic [15:0]                      drop_cnt_o;
`endif

   ast_packet_arbiter #(
      .NUM_SRC      (NUM_SRC),
      .AST_DWIDTH   (AST_DWIDTH),
      .CHANNEL_WIDTH(CHANNEL_WIDTH)
   ) dut (
      .clk_i               (clk_i),
      .arst_n_i            (arst_n_i),
      .sink_valid_i        (sink_valid_i),
      .sink_data_i         (sink_data_i),
      .sink_startofpacket_i(sink_startofpacket_i),
      .sink_endofpacket_i  (sink_endofpacket_i),
      .sink_empty_i        (sink_empty_i),
      .sink_channel_i      (sink_channel_i),
      .sink_ready_o        (sink_ready_o),
      .src_valid_o         (src_valid_o),
      .src_data_o          (src_data_o),
      .src_startofpacket_o (src_startofpacket_o),
      .src_endofpacket_o   (src_endofpacket_o),
      .src_empty_o         (src_empty_o),
      .src_channel_o       (src_channel_o),
      .src_ready_i         (src_ready_i),
      .src_id_o            (src_id_o),
`ifdef ARB_STAT_EN
      .pkt_cnt_o           (pkt_cnt_o),
      .drop_cnt_o          (drop_cnt_o),
`endif
      .busy_o              (busy_o)
   );

   typedef struct packed {
      logic [0:0]  id;
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
      logic        chan;
   } word_t;

   word_t srcq0[$];
   word_t srcq1[$];
   word_t expq[$];
   int    sopCyc[$];
   int    eopCyc[$];
   int    cyc        = 0;
   int    checks     = 0;
   int    errors     = 0;
   int    strays     = 0;
   int    xferCnt    = 0;
   int    stallStart = -1;
   int    stallLen   = 0;
   logic [1:0] acc;
   logic       prevEop;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic word_t mkWord(input int id, input logic [63:0] d, input logic s, input logic e);
      word_t w;
      w.id    = id[0];
      w.data  = d;
      w.sop   = s;
      w.eop   = e;
      w.empty = d[2:0];
      w.chan  = d[3];
      return w;
   endfunction

   // Queue one packet on a source; expected words go to the scoreboard in predicted output order.
   task automatic applyStimulus(input int src, input logic [63:0] base, input int len);
      word_t w;
      for (int i = 0; i < len; i++) begin
         w = mkWord(src, base + 64'(i), (i == 0), (i == len - 1));
         if (src == 0) srcq0.push_back(w);
         else          srcq1.push_back(w);
         expq.push_back(w);
      end
   endtask

   task automatic waitDrain(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk_i);
         #2;
         if (srcq0.size() == 0 && srcq1.size() == 0 && expq.size() == 0 && !busy_o) done = 1'b1;
      end
      checkOutput(tag, 64'(done), 64'd1);
   endtask

   task automatic flushAll();
      srcq0.delete();
      srcq1.delete();
      expq.delete();
      sopCyc.delete();
      eopCyc.delete();
      acc     = '0;
      prevEop = 1'b0;
   endtask

   task automatic doReset();
      @(posedge clk_i);
      #2;
      arst_n_i = 1'b0;
      flushAll();
      stallStart = -1;
      stallLen   = 0;
      repeat (2) @(posedge clk_i);
      #2;
      arst_n_i = 1'b1;
   endtask

   // Source models and output monitor: drive on the falling edge, sample 1 time unit later.
   initial begin
      word_t h0, h1, e;
      acc     = '0;
      prevEop = 1'b0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (acc[0] && srcq0.size() > 0) srcq0.delete(0);
         if (acc[1] && srcq1.size() > 0) srcq1.delete(0);
         h0 = (srcq0.size() > 0) ? srcq0[0] : '0;
         h1 = (srcq1.size() > 0) ? srcq1[0] : '0;
         sink_valid_i         = {srcq1.size() > 0, srcq0.size() > 0};
         sink_data_i          = {h1.data, h0.data};
         sink_startofpacket_i = {h1.sop, h0.sop};
         sink_endofpacket_i   = {h1.eop, h0.eop};
         sink_empty_i         = {h1.empty, h0.empty};
         sink_channel_i       = {h1.chan, h0.chan};
         src_ready_i          = !(cyc >= stallStart && cyc < stallStart + stallLen);
         #1;
         acc = sink_valid_i & sink_ready_o;
         for (int n = 0; n < NUM_SRC; n++) begin
            if (acc[n] && !busy_o) strays++;
         end
         if (prevEop && arst_n_i) checkOutput("busyAfterEop", 64'(busy_o), 64'd0);
         prevEop = 1'b0;
         if (!busy_o) checkOutput("idleValid", 64'(src_valid_o), 64'd0);
         if (!src_ready_i && busy_o) checkOutput("stallRdy", 64'(sink_ready_o), 64'd0);
         if (src_valid_o && src_ready_i) begin
            xferCnt++;
            if (expq.size() == 0) begin
               checkOutput("extraWord", 64'(src_data_o), 64'hDEAD_0000_0000_0000);
            end else begin
               e = expq.pop_front();
               checkOutput("id",    64'(src_id_o),            64'(e.id));
               checkOutput("data",  src_data_o,               e.data);
               checkOutput("sop",   64'(src_startofpacket_o), 64'(e.sop));
               checkOutput("eop",   64'(src_endofpacket_o),   64'(e.eop));
               checkOutput("empty", 64'(src_empty_o),         64'(e.empty));
               checkOutput("chan",  64'(src_channel_o),       64'(e.chan));
            end
            if (src_startofpacket_o) sopCyc.push_back(cyc);
            if (src_endofpacket_o) begin
               eopCyc.push_back(cyc);
               prevEop = 1'b1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int start, base, s0;
      arst_n_i             = 1'b0;
      sink_valid_i         = '0;
      sink_data_i          = '0;
      sink_startofpacket_i = '0;
      sink_endofpacket_i   = '0;
      sink_empty_i         = '0;
      sink_channel_i       = '0;
      src_ready_i          = 1'b1;
      repeat (2) @(posedge clk_i);
      #2;
      checkOutput("rstValid", 64'(src_valid_o),  64'd0);
      checkOutput("rstReady", 64'(sink_ready_o), 64'd0);
      checkOutput("rstBusy",  64'(busy_o),       64'd0);
      checkOutput("rstId",    64'(src_id_o),     64'd0);
      arst_n_i = 1'b1;

      $display("[TB] three-word packet from source 0");
      @(posedge clk_i);
      #2;
      start = cyc + 1;
      applyStimulus(0, 64'hA0, 3);
      waitDrain("t1Drain");
      checkOutput("t1Pkts", 64'(sopCyc.size()), 64'd1);
      if (sopCyc.size() >= 1 && eopCyc.size() >= 1) begin
         checkOutput("t1Lat", 64'(sopCyc[0] - start), 64'd1);
         checkOutput("t1Len", 64'(eopCyc[0] - sopCyc[0]), 64'd2);
      end
`ifdef ARB_STAT_EN
      checkOutput("t1PktCnt", 64'(pkt_cnt_o), 64'h0000_0001);
`endif

      $display("[TB] simultaneous requests alternate");
      doReset();
      applyStimulus(0, 64'hB0, 2);
      applyStimulus(1, 64'hC0, 2);
      applyStimulus(0, 64'hD0, 2);
      applyStimulus(1, 64'hE0, 2);
      waitDrain("t2Drain");
      checkOutput("t2Pkts", 64'(sopCyc.size()), 64'd4);
      if (sopCyc.size() >= 4 && eopCyc.size() >= 4) begin
         checkOutput("t2Bubble1", 64'(sopCyc[1] - eopCyc[0]), 64'd2);
         checkOutput("t2Bubble3", 64'(sopCyc[3] - eopCyc[2]), 64'd2);
      end

      $display("[TB] back-pressure on granted source 1");
      doReset();
      s0 = cyc + 1;
      applyStimulus(1, 64'h10, 5);
      @(posedge clk_i);
      #2;
      stallStart = s0 + 2;
      stallLen   = 3;
      applyStimulus(0, 64'h20, 2);
      waitDrain("t3Drain");
      checkOutput("t3Pkts", 64'(sopCyc.size()), 64'd2);
      if (sopCyc.size() >= 2 && eopCyc.size() >= 1) begin
         checkOutput("t3Span", 64'(eopCyc[0] - sopCyc[0]), 64'd7);
         checkOutput("t3Next", 64'(sopCyc[1] - eopCyc[0]), 64'd2);
      end

      $display("[TB] single-word packet");
      doReset();
      applyStimulus(0, 64'h55, 1);
      waitDrain("t4Drain");
      checkOutput("t4Pkts", 64'(eopCyc.size()), 64'd1);
      if (sopCyc.size() >= 1 && eopCyc.size() >= 1) begin
         checkOutput("t4Same", 64'(eopCyc[0] - sopCyc[0]), 64'd0);
      end

      $display("[TB] stray words discarded");
      doReset();
      base = strays;
      srcq1.push_back(mkWord(1, 64'h77, 1'b0, 1'b0));
      srcq1.push_back(mkWord(1, 64'h78, 1'b0, 1'b0));
      waitDrain("t5Drain");
      checkOutput("t5Strays", 64'(strays - base), 64'd2);
`ifdef ARB_STAT_EN
      checkOutput("t5DropCnt", 64'(drop_cnt_o), 64'd2);
`endif

      $display("[TB] reset in the middle of a packet");
      doReset();
      applyStimulus(0, 64'hF0, 4);
      base = xferCnt;
      for (int i = 0; i < 50 && (xferCnt - base) < 2; i++) begin
         @(posedge clk_i);
         #2;
      end
      checkOutput("t6Reached", 64'(xferCnt - base), 64'd2);
      arst_n_i = 1'b0;
      #1;
      checkOutput("t6Valid", 64'(src_valid_o),  64'd0);
      checkOutput("t6Ready", 64'(sink_ready_o), 64'd0);
      checkOutput("t6Busy",  64'(busy_o),       64'd0);
`ifdef ARB_STAT_EN
      checkOutput("t6PktCnt",  64'(pkt_cnt_o),  64'd0);
      checkOutput("t6DropCnt", 64'(drop_cnt_o), 64'd0);
`endif
      flushAll();
      repeat (2) @(posedge clk_i);
      #2;
      arst_n_i = 1'b1;
      applyStimulus(0, 64'h60, 2);
      applyStimulus(1, 64'h70, 2);
      waitDrain("t6Drain");
      checkOutput("t6Pkts", 64'(sopCyc.size()), 64'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ast_packet_arbiter.md
Name: ast_packet_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one packet_classer Avalon-ST sink between NUM_SRC upstream sources.
- Once granted, a source owns the output until its endofpacket word transfers, so packets are never interleaved and the classer's sop/eop framing stays intact.
- Sits directly in front of the classer sink.
- Exposes the granted source index so downstream logic can attribute the classer's channel verdict to a requester.

Parameters:
- NUM_SRC, 2, number of upstream Avalon-ST sources (2..8).
- AST_DWIDTH, 64, Avalon-ST data width; EMPTY_WIDTH = $clog2(AST_DWIDTH/8).
- CHANNEL_WIDTH, 1, Avalon-ST channel width, passed through unchanged.
- ID_WIDTH, $clog2(NUM_SRC) (min 1), width of the source index.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous active-low reset.
- sink_valid_i  in  NUM_SRC  per-source valid.
- sink_data_i  in  NUM_SRC*AST_DWIDTH  per-source data; source n occupies [n*AST_DWIDTH +: AST_DWIDTH].
- sink_startofpacket_i  in  NUM_SRC  per-source sop.
- sink_endofpacket_i  in  NUM_SRC  per-source eop.
- sink_empty_i  in  NUM_SRC*EMPTY_WIDTH  per-source empty.
- sink_channel_i  in  NUM_SRC*CHANNEL_WIDTH  per-source channel.
- sink_ready_o  out  NUM_SRC  per-source ready.
- src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o, src_empty_o, src_channel_o  out  1/AST_DWIDTH/1/1/EMPTY_WIDTH/CHANNEL_WIDTH  merged stream to the classer.
- src_ready_i  in  1  classer ready.
- src_id_o  out  ID_WIDTH  index of the source currently owning the output.
- busy_o  out  1  high while in GRANT.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, grant 0.
  - last_grant = NUM_SRC-1, so source 0 has priority first.
  - All outputs 0: src_valid_o, sink_ready_o, busy_o, src_id_o.
  - Reset mid-packet aborts the packet with no eop emitted; downstream must be reset together.
- Request:
  - req[n] = sink_valid_i[n] & sink_startofpacket_i[n].
- IDLE:
  - src_valid_o = 0.
  - If any req, select the first requesting n scanning last_grant+1, last_grant+2, … modulo NUM_SRC.
  - Register the selection into grant; go to GRANT next cycle.
  - Stray words (valid without sop) from any source are accepted and discarded: sink_ready_o[n] = sink_valid_i[n] & ~sink_startofpacket_i[n].
  - Sources that are requesting see ready 0.
- GRANT (grant = g):
  - Zero-latency combinational mux: src_* = sink_*[g]; sink_ready_o[g] = src_ready_i; all other sink_ready_o = 0.
  - A word transfers when sink_valid_i[g] & src_ready_i.
  - A transfer with eop: next state IDLE, last_grant = g.
  - A transfer with sop after the first word (nested sop) is forwarded unchanged; the arbiter ends the packet only on eop.
- Latency:
  - 1 cycle from request visible in IDLE to first word offered on src.
  - 1 idle bubble cycle between consecutive packets.
- Single-word packet (sop & eop): granted, transfers in 1 cycle, back to IDLE.
- src_ready_i low in GRANT: hold state; the source holds data per Avalon-ST.
- sink_valid_i[g] low mid-packet: src_valid_o low; no timeout.
- Outputs:
  - src_id_o = grant, registered.
  - busy_o = (state == GRANT).

Optional Feature:
- Macro ARB_STAT_EN.
- When defined, add two outputs:
  - pkt_cnt_o, NUM_SRC*16: per-source count of completed packets (eop transfers), saturating at 16'hFFFF.
  - drop_cnt_o, 16: count of discarded stray words across all sources, saturating; multiple drops in one cycle add their popcount, clamped.
- Both counters are 0 on reset.
- When undefined, these ports and the counters do not exist; all other behaviour is identical.

Test Plan:
- Source 0 sends a 3-word packet 0xA0..0xA2 and source 1 is idle, src_ready_i = 1:
  - src_data shows A0, A1, A2 on cycles 2–4 after valid; src_id_o = 0; busy_o drops after eop.
- Both sources assert sop in the same cycle after reset:
  - Source 0 is served first, then source 1 after 1 bubble cycle.
  - On the next simultaneous request, source 1 (as last_grant+1 of 0) … order alternates 0,1,0,1.
- Source 1 granted, src_ready_i low for 3 cycles mid-packet:
  - sink_ready_o[1] = 0 for those cycles; no words lost or duplicated; source 0's sop waits (ready 0).
- Source 0 sends a single-word packet (sop & eop):
  - Transfers in 1 cycle; IDLE next cycle; src_endofpacket_o = 1 with the word.
- Source 1 drives valid without sop in IDLE for 2 words:
  - sink_ready_o[1] = 1 for both, src_valid_o = 0; with ARB_STAT_EN, drop_cnt_o = 2.
- arst_n_i asserted in the middle of a 4-word packet:
  - src_valid_o and sink_ready_o go to 0 immediately; after release, source 0 has priority; with ARB_STAT_EN, counters read 0.
